// File: rtl/fence_sequencer_if.sv
// Request/flush-fabric bundle between the commit stage, the fence sequencer
// and the cache/TLB flush fabric. The sequencer takes the slave side.
interface fence_sequencer_if;
    logic       v_i;
    logic       req_valid_i;
    logic [2:0] req_type_i;
    logic       req_ready_o;
    logic       flush_pipe_o;
    logic       flush_dcache_o;
    logic       flush_dcache_ack_i;
    logic       flush_icache_o;
    logic       flush_tlb_o;
    logic       flush_tlb_vvma_o;
    logic       flush_tlb_gvma_o;
    logic       halt_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;

    modport slave (
        input  v_i, req_valid_i, req_type_i, flush_dcache_ack_i,
        output req_ready_o, flush_pipe_o, flush_dcache_o, flush_icache_o,
               flush_tlb_o, flush_tlb_vvma_o, flush_tlb_gvma_o,
               halt_o, busy_o, done_o, err_o
    );

    modport master (
        output v_i, req_valid_i, req_type_i, flush_dcache_ack_i,
        input  req_ready_o, flush_pipe_o, flush_dcache_o, flush_icache_o,
               flush_tlb_o, flush_tlb_vvma_o, flush_tlb_gvma_o,
               halt_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/fence_sequencer.sv
// Fence sequencer: serializes FENCE / FENCE.I / SFENCE.VMA / HFENCE.* requests
// through pipe flush, D-cache flush handshake (with timeout), I-cache flush and
// TLB flush, holding the commit stage halted until the sequence completes.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | ready for a request; all flush outputs quiet
// S_PIPE    | one-cycle pipeline flush pulse, route by request type
// S_DC_WAIT | D-cache flush level held until ack or timeout
// S_IC      | one-cycle I-cache flush pulse
// S_TLB     | one-cycle pulse on exactly one TLB flush output
// S_DONE    | done pulse with error flag, back to idle
module fence_sequencer #(
    parameter bit          DCACHE_WT      = 1'b0,
    parameter bit          RVH            = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    fence_sequencer_if.slave  bus
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] T_FENCE       = 3'd0;
    localparam logic [2:0] T_FENCE_I     = 3'd1;
    localparam logic [2:0] T_SFENCE_VMA  = 3'd2;
    localparam logic [2:0] T_HFENCE_VVMA = 3'd3;
    localparam logic [2:0] T_HFENCE_GVMA = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PIPE,
        S_DC_WAIT,
        S_IC,
        S_TLB,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       type_q, type_d;
    logic             v_q, v_d;
    logic             illegal_q, illegal_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             req_illegal;
    logic             is_tlb_type;
    logic             dc_needed;

    assign req_illegal = (bus.req_type_i > T_HFENCE_GVMA) ||
                         (!RVH && ((bus.req_type_i == T_HFENCE_VVMA) ||
                                   (bus.req_type_i == T_HFENCE_GVMA)));
    assign is_tlb_type = (type_q == T_SFENCE_VMA) || (type_q == T_HFENCE_VVMA) ||
                         (type_q == T_HFENCE_GVMA);
    assign dc_needed   = !DCACHE_WT && ((type_q == T_FENCE) || (type_q == T_FENCE_I));

    // State and request context registers; reset drops everything to idle at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            type_q    <= 3'd0;
            v_q       <= 1'b0;
            illegal_q <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            v_q       <= v_d;
            illegal_q <= illegal_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state sequencing and Moore output decode from the registered state.
    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        v_d       = v_q;
        illegal_d = illegal_q;
        err_d     = err_q;
        cnt_d     = cnt_q;

        // Ready is held low while reset is asserted so every output reads 0.
        bus.req_ready_o      = (state_q == S_IDLE) && !rst_i;
        bus.flush_pipe_o     = 1'b0;
        bus.flush_dcache_o   = 1'b0;
        bus.flush_icache_o   = 1'b0;
        bus.flush_tlb_o      = 1'b0;
        bus.flush_tlb_vvma_o = 1'b0;
        bus.flush_tlb_gvma_o = 1'b0;
        bus.halt_o           = (state_q != S_IDLE);
        bus.busy_o           = (state_q != S_IDLE);
        bus.done_o           = 1'b0;
        bus.err_o            = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid_i) begin
                    type_d    = bus.req_type_i;
                    v_d       = bus.v_i;
                    illegal_d = req_illegal;
                    err_d     = req_illegal;
                    state_d   = S_PIPE;
                end
            end
            S_PIPE: begin
                bus.flush_pipe_o = 1'b1;
                cnt_d            = '0;
                if (dc_needed) begin
                    state_d = S_DC_WAIT;
                end else if (type_q == T_FENCE_I) begin
                    state_d = S_IC;
                end else if (is_tlb_type && !illegal_q) begin
                    state_d = S_TLB;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DC_WAIT: begin
                bus.flush_dcache_o = 1'b1;
                if (bus.flush_dcache_ack_i || (cnt_q == CNT_LAST)) begin
                    // An ack arriving in the timeout cycle still counts as success.
                    if (!bus.flush_dcache_ack_i) begin
                        err_d = 1'b1;
                    end
                    state_d = (type_q == T_FENCE_I) ? S_IC : S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_IC: begin
                bus.flush_icache_o = 1'b1;
                state_d            = S_DONE;
            end
            S_TLB: begin
                if (type_q == T_HFENCE_GVMA) begin
                    bus.flush_tlb_gvma_o = 1'b1;
                end else if ((type_q == T_HFENCE_VVMA) || (RVH && v_q)) begin
                    bus.flush_tlb_vvma_o = 1'b1;
                end else begin
                    bus.flush_tlb_o = 1'b1;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                bus.done_o = 1'b1;
                bus.err_o  = err_q;
                err_d      = 1'b0;
                illegal_d  = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fence_sequencer.sv
// Bench for fence_sequencer: three configurations (write-back with RVH,
// write-through, write-back without RVH and a short timeout) each driven with
// a directed list and random requests, compared cycle by cycle against an
// expected output schedule built per request from the sequencing rules.
module tb_fence_sequencer;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    always #5 clk_i = ~clk_i;

    // Output vector: {ready, pipe, dcache, icache, tlb, vvma, gvma, halt, busy, done, err}
    localparam logic [10:0] E_ZERO = 11'b000_0000_0000;
    localparam logic [10:0] E_IDLE = 11'b100_0000_0000;
    localparam logic [10:0] E_BUSY = 11'b000_0000_1100;
    localparam logic [10:0] E_PIPE = E_BUSY | 11'b010_0000_0000;
    localparam logic [10:0] E_DC   = E_BUSY | 11'b001_0000_0000;
    localparam logic [10:0] E_IC   = E_BUSY | 11'b000_1000_0000;
    localparam logic [10:0] E_TLB  = E_BUSY | 11'b000_0100_0000;
    localparam logic [10:0] E_VVMA = E_BUSY | 11'b000_0010_0000;
    localparam logic [10:0] E_GVMA = E_BUSY | 11'b000_0001_0000;
    localparam logic [10:0] E_DONE = E_BUSY | 11'b000_0000_0010;

    logic        valid_d [3];
    logic [2:0]  type_d  [3];
    logic        v_d     [3];
    logic        ack_d   [3];
    logic [10:0] obs     [3];

    int nvec = 0;
    int nerr = 0;

    fence_sequencer_if bus0 ();
    fence_sequencer_if bus1 ();
    fence_sequencer_if bus2 ();

    fence_sequencer #(.DCACHE_WT(1'b0), .RVH(1'b1), .TIMEOUT_CYCLES(8)) u_dut0 (
        .clk_i(clk_i), .rst_i(rst_i), .bus(bus0));
    fence_sequencer #(.DCACHE_WT(1'b1), .RVH(1'b1), .TIMEOUT_CYCLES(8)) u_dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .bus(bus1));
    fence_sequencer #(.DCACHE_WT(1'b0), .RVH(1'b0), .TIMEOUT_CYCLES(3)) u_dut2 (
        .clk_i(clk_i), .rst_i(rst_i), .bus(bus2));

    assign bus0.req_valid_i = valid_d[0];
    assign bus0.req_type_i  = type_d[0];
    assign bus0.v_i         = v_d[0];
    assign bus0.flush_dcache_ack_i = ack_d[0];
    assign bus1.req_valid_i = valid_d[1];
    assign bus1.req_type_i  = type_d[1];
    assign bus1.v_i         = v_d[1];
    assign bus1.flush_dcache_ack_i = ack_d[1];
    assign bus2.req_valid_i = valid_d[2];
    assign bus2.req_type_i  = type_d[2];
    assign bus2.v_i         = v_d[2];
    assign bus2.flush_dcache_ack_i = ack_d[2];

    assign obs[0] = {bus0.req_ready_o, bus0.flush_pipe_o, bus0.flush_dcache_o, bus0.flush_icache_o,
                     bus0.flush_tlb_o, bus0.flush_tlb_vvma_o, bus0.flush_tlb_gvma_o,
                     bus0.halt_o, bus0.busy_o, bus0.done_o, bus0.err_o};
    assign obs[1] = {bus1.req_ready_o, bus1.flush_pipe_o, bus1.flush_dcache_o, bus1.flush_icache_o,
                     bus1.flush_tlb_o, bus1.flush_tlb_vvma_o, bus1.flush_tlb_gvma_o,
                     bus1.halt_o, bus1.busy_o, bus1.done_o, bus1.err_o};
    assign obs[2] = {bus2.req_ready_o, bus2.flush_pipe_o, bus2.flush_dcache_o, bus2.flush_icache_o,
                     bus2.flush_tlb_o, bus2.flush_tlb_vvma_o, bus2.flush_tlb_gvma_o,
                     bus2.halt_o, bus2.busy_o, bus2.done_o, bus2.err_o};

    function automatic bit cfg_wt(int d);
        return d == 1;
    endfunction

    function automatic bit cfg_rvh(int d);
        return d != 2;
    endfunction

    function automatic int cfg_to(int d);
        return (d == 2) ? 3 : 8;
    endfunction

    task automatic chk_vec(string tag, logic [10:0] got, logic [10:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    // Check this cycle's outputs, then drive this cycle's inputs.
    task automatic step(int d, logic [10:0] exp, logic vld, logic [2:0] ty, logic v, logic ack,
                        string tag);
        @(negedge clk_i);
        chk_vec($sformatf("d%0d %s", d, tag), obs[d], exp);
        valid_d[d] = vld;
        type_d[d]  = ty;
        v_d[d]     = v;
        ack_d[d]   = ack;
    endtask

    // Busy cycle: requester may hold valid with arbitrary type, ack is noise.
    task automatic step_junk(int d, logic [10:0] exp, string tag);
        step(d, exp, 1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), tag);
    endtask

    // One request: k is the DC_WAIT cycle index of the ack (k >= timeout means none).
    task automatic run_txn(int d, logic [2:0] ty, logic v, int k, int gap);
        int  to      = cfg_to(d);
        bit  wt      = cfg_wt(d);
        bit  rvh     = cfg_rvh(d);
        bit  illegal = (ty >= 3'd5) || (((ty == 3'd3) || (ty == 3'd4)) && !rvh);
        bit  err     = illegal;
        step(d, E_IDLE, 1'b1, ty, v, 1'($urandom), "accept");
        step_junk(d, E_PIPE, "pipe");
        if ((ty <= 3'd1) && !wt) begin
            int n = (k < to) ? k + 1 : to;
            err = (k >= to);
            for (int j = 0; j < n; j++) begin
                step(d, E_DC, 1'($urandom), 3'($urandom), 1'($urandom), 1'(j == k), "dc_wait");
            end
            if (ty == 3'd1) step_junk(d, E_IC, "icache");
        end else if (ty == 3'd1) begin
            step_junk(d, E_IC, "icache");
        end else if (!illegal && (ty == 3'd2)) begin
            step_junk(d, (rvh && v) ? E_VVMA : E_TLB, "tlb_sfence");
        end else if (!illegal && (ty == 3'd3)) begin
            step_junk(d, E_VVMA, "tlb_hvvma");
        end else if (!illegal && (ty == 3'd4)) begin
            step_junk(d, E_GVMA, "tlb_hgvma");
        end
        step_junk(d, E_DONE | {10'd0, err}, "done");
        for (int g = 0; g < gap; g++) begin
            step(d, E_IDLE, 1'b0, 3'($urandom), 1'($urandom), 1'($urandom), "idle");
        end
    endtask

    int dir_ty [10] = '{0, 1, 0, 0, 2, 2, 4, 3, 6, 1};
    int dir_v  [10] = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 1};
    int dir_k  [10] = '{3, 0, 99, 7, 0, 0, 0, 0, 0, 2};

    initial begin
        for (int d = 0; d < 3; d++) begin
            valid_d[d] = 1'b0;
            type_d[d]  = 3'd0;
            v_d[d]     = 1'b0;
            ack_d[d]   = 1'b0;
        end
        repeat (2) @(negedge clk_i);
        for (int d = 0; d < 3; d++) chk_vec($sformatf("d%0d in_reset", d), obs[d], E_ZERO);
        rst_i = 1'b0;

        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 10; i++) begin
                run_txn(d, 3'(dir_ty[i]), 1'(dir_v[i]), dir_k[i], i % 3);
            end
            for (int i = 0; i < 40; i++) begin
                run_txn(d, 3'($urandom), 1'($urandom), $urandom_range(0, cfg_to(d) + 1),
                        $urandom_range(0, 3));
            end
        end

        // Drive config 0 into DC_WAIT and hit it with reset mid-cycle.
        step(0, E_IDLE, 1'b1, 3'd0, 1'b0, 1'b0, "rst_accept");
        step(0, E_PIPE, 1'b0, 3'd0, 1'b0, 1'b0, "rst_pipe");
        step(0, E_DC,   1'b0, 3'd0, 1'b0, 1'b0, "rst_dc");
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        for (int d = 0; d < 3; d++) ack_d[d] = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) chk_vec($sformatf("d%0d async_rst", d), obs[d], E_ZERO);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 3; i++) step(d, E_IDLE, 1'b0, 3'd0, 1'b0, 1'b1, "stale_ack");
        end
        run_txn(0, 3'd0, 1'b0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
